// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM generator.
// Holds the FSM state encoding and default widths.
package pwm_pkg;

    // Default width of the upstream count; period = 2**WIDTH cycles.
    localparam int PWM_WIDTH_DEF = 4;
    // Default width of the wrapping period tally.
    localparam int PCNT_W_DEF    = 8;

    typedef enum logic [1:0] {
        DISABLED  = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_gen_if.sv
// Duty-cycle load channel (valid/ready) for pwm_gen.
// Ports: duty_in, duty_valid (master->slave), duty_ready (slave->master).
interface pwm_gen_if #(
    parameter int WIDTH = 4
) ();

    logic [WIDTH:0] duty_in;
    logic           duty_valid;
    logic           duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );

endinterface

// File: rtl/pwm_gen_duty_shadow.sv
// Double-buffered duty register: one pending slot plus the active duty.
// Ports: clk, reset, boundary, duty_in/valid/ready, active_duty_next.
module duty_shadow
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             boundary,
    input  logic [WIDTH:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic [WIDTH:0]   active_duty_next
);

    localparam logic [WIDTH:0] DUTY_MAX = {1'b1, {WIDTH{1'b0}}};

    logic [WIDTH:0] pending_duty_q;
    logic [WIDTH:0] pending_duty_d;
    logic [WIDTH:0] active_duty_q;
    logic [WIDTH:0] active_duty_d;
    logic           pending_flag_q;
    logic           pending_flag_d;
    logic           transfer;

    assign duty_ready = ~pending_flag_q & ~reset;
    assign transfer   = duty_valid & duty_ready;

    // A transfer needs an empty slot, so it can never coincide with a
    // commit; a value captured on a boundary waits for the next one.
    always_comb begin
        pending_duty_d = pending_duty_q;
        pending_flag_d = pending_flag_q;
        active_duty_d  = active_duty_q;
        if (boundary && pending_flag_q) begin
            active_duty_d  = pending_duty_q;
            pending_flag_d = 1'b0;
        end else if (transfer) begin
            pending_duty_d = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
            pending_flag_d = 1'b1;
        end
    end

    // The compare in the top uses the value being loaded this edge.
    assign active_duty_next = active_duty_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_duty_q <= '0;
            pending_flag_q <= 1'b0;
            active_duty_q  <= '0;
        end else begin
            pending_duty_q <= pending_duty_d;
            pending_flag_q <= pending_flag_d;
            active_duty_q  <= active_duty_d;
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// PWM generator slaved to an external free-running up-counter.
// Ports: clk, reset, count_in, enable, duty_if (load channel),
//        pwm_out, period_start, periods, running.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH  = PWM_WIDTH_DEF,
    parameter int PCNT_W = PCNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              enable,
    pwm_gen_if.slave          duty_if,
    output logic              pwm_out,
    output logic              period_start,
    output logic [PCNT_W-1:0] periods,
    output logic              running
);

    pwm_state_e        state_q;
    pwm_state_e        state_d;
    logic              pwm_q;
    logic              pwm_d;
    logic              period_start_q;
    logic              period_start_d;
    logic [PCNT_W-1:0] periods_q;
    logic [PCNT_W-1:0] periods_d;
    logic              boundary;
    logic [WIDTH:0]    active_duty_next;

    // Any cycle showing zero starts a period, including an upstream reset.
    assign boundary = (count_in == '0);

    duty_shadow #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk              (clk),
        .reset            (reset),
        .boundary         (boundary),
        .duty_in          (duty_if.duty_in),
        .duty_valid       (duty_if.duty_valid),
        .duty_ready       (duty_if.duty_ready),
        .active_duty_next (active_duty_next)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DISABLED:  state_d = WAIT_SYNC;
            WAIT_SYNC: if (boundary) state_d = RUN;
            RUN:       state_d = RUN;
            default:   state_d = DISABLED;
        endcase
        if (!enable) begin
            state_d = DISABLED;
        end
    end

    // Keying outputs off the next state covers both steady RUN and the
    // WAIT_SYNC->RUN edge, and silences pwm the cycle enable drops.
    always_comb begin
        pwm_d          = 1'b0;
        period_start_d = 1'b0;
        periods_d      = periods_q;
        if (state_d == RUN) begin
            pwm_d = ({1'b0, count_in} < active_duty_next);
            if (boundary) begin
                period_start_d = 1'b1;
                periods_d      = periods_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= DISABLED;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            periods_q      <= '0;
        end else begin
            state_q        <= state_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            periods_q      <= periods_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign periods      = periods_q;
    assign running      = (state_q == RUN);

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Downstream consumer of the free-running synchronous up-counter's count value.
- Converts the count into a PWM waveform whose duty cycle is set via a valid/ready load interface.
- A new duty is double-buffered and takes effect only at a period boundary, so no period is ever partial or glitched.
- Also emits a period-start strobe and a wrapping period tally for downstream monitoring.

Parameters:
- WIDTH, 4, width of count_in; period = 2**WIDTH cycles.
- PCNT_W, 8, width of the periods tally.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  value from the upstream counter; wraps MAX->0.
- enable  input  1  run request.
- duty_in  input  WIDTH+1  requested high-cycles per period, legal range 0..2**WIDTH.
- duty_valid  input  1  duty_in is valid this cycle.
- duty_ready  output  1  pending slot is empty; a transfer occurs when duty_valid && duty_ready.
- pwm_out  output  1  registered PWM output.
- period_start  output  1  one-cycle strobe at each period boundary while running.
- periods  output  PCNT_W  completed period-start count; wraps.
- running  output  1  high in state RUN.

Behaviour:
- Reset (synchronous, while reset=1 at the edge):
  - state=DISABLED; pwm_out=0, period_start=0, periods=0, running=0.
  - active_duty=0; pending_flag=0.
  - duty_ready=0 while reset is high, 1 on the first cycle after release.
- duty_ready = ~pending_flag & ~reset (combinational).
- Load handshake:
  - On transfer: pending_duty<=duty_in, pending_flag<=1.
  - duty_in > 2**WIDTH is clamped to 2**WIDTH at capture.
- Boundary: cycle where count_in==0.
  - If pending_flag=1: active_duty<=pending_duty and pending_flag<=0 at that edge.
  - A transfer in the same cycle as a boundary is NOT applied at that boundary; it stays pending until the next one.
  - Shadow update happens in all states, including DISABLED.
- FSM states: DISABLED, WAIT_SYNC, RUN.
  - DISABLED -> WAIT_SYNC when enable=1.
  - WAIT_SYNC -> RUN on a boundary cycle (count_in==0).
  - RUN stays in RUN while enable=1.
  - Any state -> DISABLED when enable=0 (same edge).
- Outputs (registered, latency 1 cycle from count_in):
  - In RUN, or on the WAIT_SYNC->RUN transition edge: pwm_out<=(count_in < active_duty_next).
    - active_duty_next is the value being loaded at this edge, so a boundary update affects that same cycle's compare.
  - Otherwise pwm_out<=0.
  - period_start<=1 on a boundary cycle when the next state is RUN.
  - periods increments on the same condition; wraps 2**PCNT_W-1 -> 0.
- Duty edge cases:
  - duty=0: pwm_out constantly 0.
  - duty=2**WIDTH: constantly 1.
  - duty=k: exactly k high cycles per period, starting at the boundary.
- Upstream irregularity:
  - If the counter is reset mid-period (count_in forced to 0), that cycle is a boundary.
  - A new period starts and a pending duty is applied; no error flag.
- enable dropped mid-period: pwm_out=0 from the next cycle. Re-enable waits for the next boundary; no partial period.
- reset mid-operation: all state cleared, including any pending duty (it is lost).

Decomposition:
- Package pwm_pkg holds:
  - typedef enum for the FSM states {DISABLED, WAIT_SYNC, RUN}, 2 bits.
  - Default WIDTH/PCNT_W constants.
- One sub-module: duty_shadow. It contains the valid/ready capture, clamp, pending_flag and boundary commit, and outputs active_duty_next.
- Top level keeps the FSM, compare and strobe/tally logic.

Test Plan:
- Reset held 2 cycles, then enable=1 with no duty load. Expect pwm_out=0 throughout, running=1 after the first count_in==0, period_start every 16 cycles, periods 0->1->2.
- Load duty=5 while disabled, enable=1, upstream counting 0..15. Expect the first boundary to commit 5; each period then has pwm_out high exactly 5 cycles (count 0..4, seen 1 cycle late), low 11.
- Running at duty=5, load duty=12 at count_in=7. Expect duty_ready=0 until the next boundary, 5 high cycles for the rest of that period, 12 high cycles from the next period on, and duty_ready=1 after the commit.
- Transfer of duty=3 exactly on a count_in==0 cycle. Expect it not applied that period; applied at the following boundary. A second valid while pending sees duty_ready=0 and is not accepted.
- duty_in=0 then duty_in=16 then duty_in=31. Expect a period fully low, then fully high, then fully high (31 clamped to 16).
- Running, drop enable at count_in=9 and raise it at count_in=12. Expect pwm_out=0 the next cycle, running=0, WAIT_SYNC until count_in==0, then resume with no partial period. Repeat with reset asserted mid-period: pending duty cleared, periods=0.
